// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch - PC register, fetch-address AdEL detection and IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LAST    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] EPC,
  input  logic [1:0]  NPCOp_ID,
  input  logic [31:0] npcValue_ID,
  input  logic        isJump_ID,
  output logic [31:0] IMAddr,
  input  logic [31:0] IMData,
  output logic [31:0] PC_IF,
  output logic [31:0] Instr_ID,
  output logic [31:0] PC_ID,
  output logic [4:0]  ExcCode_ID,
  output logic        BD_ID
);
  logic        fetchExc;
  logic [31:0] fetchWord;
  logic [4:0]  fetchCode;
  logic [31:0] nextPc;
  assign IMAddr = PC_IF;
  always_comb begin
    fetchExc  = (|PC_IF[1:0]) || (PC_IF < IM_BASE) || (PC_IF > IM_LAST);
    fetchWord = fetchExc ? 32'h0 : IMData;
    fetchCode = fetchExc ? 5'd4 : 5'd0;
    nextPc    = eret ? EPC : (|NPCOp_ID) ? npcValue_ID : PC_IF + 32'd4;
  end
  // req outranks stall; eret squashes the fetched slot into a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_IF      <= RESET_PC;
      Instr_ID   <= 32'h0;
      PC_ID      <= RESET_PC;
      ExcCode_ID <= 5'd0;
      BD_ID      <= 1'b0;
    end else if (req) begin
      PC_IF      <= HANDLER_PC;
      Instr_ID   <= 32'h0;
      PC_ID      <= PC_IF;
      ExcCode_ID <= 5'd0;
      BD_ID      <= 1'b0;
    end else if (!stall) begin
      PC_IF      <= nextPc;
      Instr_ID   <= eret ? 32'h0 : fetchWord;
      PC_ID      <= PC_IF;
      ExcCode_ID <= eret ? 5'd0 : fetchCode;
      BD_ID      <= !eret && isJump_ID;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan checks plus randomized run against a behavioural fetch-stage model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset, stall, req, eret, isJump_ID;
  logic [31:0] EPC, npcValue_ID, IMAddr, IMData, PC_IF, Instr_ID, PC_ID;
  logic [1:0]  NPCOp_ID;
  logic [4:0]  ExcCode_ID;
  logic        BD_ID;
  logic        constMode, chkOn;
  int          nCmp = 0, nBad = 0;
  logic [31:0] mPc, mInstr, mPcId;
  logic [4:0]  mExc;
  logic        mBd;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .EPC(EPC),
    .NPCOp_ID(NPCOp_ID), .npcValue_ID(npcValue_ID), .isJump_ID(isJump_ID),
    .IMAddr(IMAddr), .IMData(IMData), .PC_IF(PC_IF), .Instr_ID(Instr_ID),
    .PC_ID(PC_ID), .ExcCode_ID(ExcCode_ID), .BD_ID(BD_ID)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return constMode ? 32'h2408_0001 : ({a[15:0], ~a[31:16]} ^ 32'h5a5a_1234);
  endfunction

  assign IMData = mem(IMAddr);

  function automatic bit badFetch(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: each edge applies the highest-priority rule to the architectural state
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mPc <= 32'h3000; mInstr <= 0; mPcId <= 32'h3000; mExc <= 0; mBd <= 0;
    end else if (req) begin
      mPc <= 32'h4180; mInstr <= 0; mPcId <= mPc; mExc <= 0; mBd <= 0;
    end else if (stall) begin
      mPc <= mPc;
    end else if (eret) begin
      mPc <= EPC; mInstr <= 0; mPcId <= mPc; mExc <= 0; mBd <= 0;
    end else begin
      mPc    <= (NPCOp_ID != 0) ? npcValue_ID : mPc + 32'd4;
      mInstr <= badFetch(mPc) ? 32'h0 : mem(mPc);
      mPcId  <= mPc;
      mExc   <= badFetch(mPc) ? 5'd4 : 5'd0;
      mBd    <= isJump_ID;
    end
  end

  always @(negedge clk) begin
    if (chkOn) begin
      chk("PC_IF", PC_IF, mPc);
      chk("IMAddr", IMAddr, mPc);
      chk("Instr_ID", Instr_ID, mInstr);
      chk("PC_ID", PC_ID, mPcId);
      chk("ExcCode_ID", {27'h0, ExcCode_ID}, {27'h0, mExc});
      chk("BD_ID", {31'h0, BD_ID}, {31'h0, mBd});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; req = 0; eret = 0; NPCOp_ID = 0; isJump_ID = 0;
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 7))
      0: return $urandom;
      1: return 32'h3000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      2: return 32'h6FF0 + ($urandom_range(0, 7) << 2);
      default: return 32'h3000 + ($urandom_range(0, 12'hFFF) << 2);
    endcase
  endfunction

  initial begin
    chkOn = 0; constMode = 1; reset = 1; EPC = 0; npcValue_ID = 0;
    idle();
    #2 reset = 0;
    chkOn = 1;
    #1;
    chk("rst PC_IF", PC_IF, 32'h3000);
    chk("rst PC_ID", PC_ID, 32'h3000);
    chk("rst Instr_ID", Instr_ID, 32'h0);
    chk("rst BD_ID", {31'h0, BD_ID}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    #1 chk("first fetch", PC_IF, 32'h3000);
    cyc();
    chk("run PC 3004", PC_IF, 32'h3004);
    chk("run Instr", Instr_ID, 32'h2408_0001);
    chk("run PC_ID", PC_ID, 32'h3000);
    cyc();
    chk("run PC 3008", PC_IF, 32'h3008);
    NPCOp_ID = 1; npcValue_ID = 32'h3100; isJump_ID = 1;
    cyc();
    chk("br PC_IF", PC_IF, 32'h3100);
    chk("br PC_ID", PC_ID, 32'h3008);
    chk("br BD_ID", {31'h0, BD_ID}, 32'h1);
    isJump_ID = 0; npcValue_ID = 32'h3010;
    cyc();
    chk("to 3010", PC_IF, 32'h3010);
    stall = 1; npcValue_ID = 32'h3200;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall PC_IF", PC_IF, 32'h3010);
      chk("stall PC_ID", PC_ID, 32'h3100);
      chk("stall Instr", Instr_ID, 32'h2408_0001);
    end
    stall = 0;
    cyc();
    chk("unstall PC_IF", PC_IF, 32'h3200);
    npcValue_ID = 32'h3020;
    cyc();
    chk("to 3020", PC_IF, 32'h3020);
    NPCOp_ID = 0; req = 1; stall = 1;
    cyc();
    chk("req PC_IF", PC_IF, 32'h4180);
    chk("req Instr", Instr_ID, 32'h0);
    chk("req Exc", {27'h0, ExcCode_ID}, 32'h0);
    chk("req PC_ID", PC_ID, 32'h3020);
    idle(); eret = 1; EPC = 32'h3044;
    cyc();
    chk("eret PC_IF", PC_IF, 32'h3044);
    chk("eret Instr", Instr_ID, 32'h0);
    idle(); NPCOp_ID = 1; npcValue_ID = 32'h3002;
    cyc();
    chk("to 3002", PC_IF, 32'h3002);
    isJump_ID = 1; npcValue_ID = 32'h7000;
    cyc();
    chk("ad3002 PC_IF", PC_IF, 32'h7000);
    chk("ad3002 Instr", Instr_ID, 32'h0);
    chk("ad3002 Exc", {27'h0, ExcCode_ID}, 32'h4);
    chk("ad3002 BD", {31'h0, BD_ID}, 32'h1);
    chk("ad3002 PC_ID", PC_ID, 32'h3002);
    idle();
    cyc();
    chk("ad7000 Instr", Instr_ID, 32'h0);
    chk("ad7000 Exc", {27'h0, ExcCode_ID}, 32'h4);
    chk("ad7000 BD", {31'h0, BD_ID}, 32'h0);
    chk("ad7000 PC_IF", PC_IF, 32'h7004);
    eret = 1; EPC = 32'hFFFF_FFFC;
    cyc();
    eret = 0;
    chk("wrap pre", PC_IF, 32'hFFFF_FFFC);
    cyc();
    chk("wrap PC_IF", PC_IF, 32'h0);
    chk("wrap Exc", {27'h0, ExcCode_ID}, 32'h4);
    NPCOp_ID = 1; npcValue_ID = 32'h6FFC;
    cyc();
    NPCOp_ID = 0;
    cyc();
    chk("last legal Exc", {27'h0, ExcCode_ID}, 32'h0);
    chk("last legal Instr", Instr_ID, 32'h2408_0001);
    constMode = 0;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) != 0);
      req         = ($urandom_range(0, 15) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      eret        = ($urandom_range(0, 15) == 0);
      NPCOp_ID    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      npcValue_ID = randAddr();
      EPC         = randAddr();
      isJump_ID   = 1'($urandom_range(0, 1));
      cyc();
    end
    reset = 1; idle();
    cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, drives the instruction-memory address, detects fetch-address exceptions, and holds the IF/ID pipeline register that feeds the decode stage. Next-PC selection consumes the decode stage's branch/jump decision (`NPCOp_ID`, `npcValue_ID`, `isJump_ID`) and the CP0 redirect controls (`req`, `eret`, `EPC`). Delay-slot semantics apply: the instruction fetched while a jump is in ID always executes.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value after reset.
- `HANDLER_PC`, 32'h0000_4180, exception entry address.
- `IM_BASE`, 32'h0000_3000, lowest legal fetch address.
- `IM_LAST`, 32'h0000_6FFC, highest legal fetch address.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `stall` in 1: hazard stall from the decode stage; holds PC and IF/ID.
- `req` in 1: CP0 exception/interrupt redirect.
- `eret` in 1: eret is in ID; redirect to `EPC`.
- `EPC` in 32: return address from CP0.
- `NPCOp_ID` in 2: 0 means sequential; nonzero means a taken branch or jump.
- `npcValue_ID` in 32: target address when `NPCOp_ID` is nonzero.
- `isJump_ID` in 1: the instruction in ID is a branch or jump, so the instruction in IF is its delay slot.
- `IMAddr` out 32: instruction-memory address; combinational, equal to `PC_IF`.
- `IMData` in 32: instruction word read combinationally at `IMAddr`.
- `PC_IF` out 32: current fetch PC.
- `Instr_ID` out 32: IF/ID instruction.
- `PC_ID` out 32: IF/ID PC.
- `ExcCode_ID` out 5: IF/ID exception code, fed to ID's `ExcCode_in`.
- `BD_ID` out 1: IF/ID branch-delay flag.

## Operation
- Fetch exception (combinational): when `PC_IF[1:0] != 0`, or `PC_IF < IM_BASE`, or `PC_IF > IM_LAST`, the fetch code is 5'd4 (AdEL) and the fetched word is forced to 32'h0. Otherwise the code is 5'd0 and the fetched word is `IMData`.
- Next-PC priority, highest first:
  1. `req`: PC <= `HANDLER_PC`. IF/ID loads a bubble.
  2. `stall`: PC holds and IF/ID holds.
  3. `eret`: PC <= `EPC`. IF/ID loads a bubble, because the slot after eret is discarded.
  4. `NPCOp_ID != 0`: PC <= `npcValue_ID`. IF/ID loads the fetched word, which is the delay slot.
  5. Otherwise: PC <= `PC_IF + 4`, computed mod 2^32 with wrap-around and no trap. IF/ID loads the fetched word.
- Normal IF/ID load: `Instr_ID` <= fetched word; `PC_ID` <= `PC_IF`; `ExcCode_ID` <= fetch code; `BD_ID` <= `isJump_ID`.
- Bubble: `Instr_ID` = 0, `ExcCode_ID` = 0, `BD_ID` = 0, `PC_ID` <= `PC_IF`. Keeping the PC preserves a valid macroscopic PC for CP0.
- A misaligned or out-of-range `npcValue_ID` or `EPC` is loaded into the PC as-is. The AdEL is raised when that address is fetched, and carries `BD_ID` = 1 if it sits in a delay slot.

## Timing
- Reset asserted (`reset` = 0), effective immediately: `PC_IF` = `RESET_PC`, `Instr_ID` = 0, `PC_ID` = `RESET_PC`, `ExcCode_ID` = 0, `BD_ID` = 0.
- On release of `reset`, the first fetch is from `RESET_PC`. Reset asserted mid-stream discards all in-flight state.
- Latency: one cycle from `PC_IF` to `Instr_ID`. A redirect presented in cycle N makes `PC_IF` equal the target in cycle N+1.
- Stall with a taken branch in the same cycle: the branch is not acted on. ID re-evaluates it on the following unstalled cycle.
- `req` with `stall` or `eret` in the same cycle: `req` wins and the bubble is loaded.
- `stall` with `eret` in the same cycle: hold. eret is re-presented next cycle.

## Test plan
- Reset then free-run, `IMData` = 32'h2408_0001: `PC_IF` steps 0x3000, 0x3004, 0x3008. `Instr_ID` = 32'h2408_0001 with `PC_ID` = 0x3000 one cycle after reset release.
- Taken branch: `NPCOp_ID` = 1, `npcValue_ID` = 0x3100, `isJump_ID` = 1 while `PC_IF` = 0x3008. Next cycle `PC_IF` = 0x3100, `PC_ID` = 0x3008, `BD_ID` = 1.
- Stall for 3 cycles at `PC_IF` = 0x3010 with `NPCOp_ID` = 1: `PC_IF`, `Instr_ID` and `PC_ID` are frozen for all 3 cycles. When `stall` drops, `PC_IF` = `npcValue_ID`.
- `req` together with `stall` at `PC_IF` = 0x3020: next cycle `PC_IF` = 0x4180, `Instr_ID` = 0, `ExcCode_ID` = 0.
- `eret` with `EPC` = 0x3044: next cycle `PC_IF` = 0x3044 and `Instr_ID` = 0 (bubble).
- Fetch fault: jump to 0x3002, then to 0x7000. Each cycles out `Instr_ID` = 0 and `ExcCode_ID` = 5'd4. The 0x3002 fetch shows `BD_ID` = 1 because it is the delay-slot fetch.
